// File: rtl/mips_core.sv
`default_nettype none
// ============================================================================
//  Module      : mips_core
//  Description : Single-cycle 32-bit MIPS datapath and control. It fetches the
//                instruction at pc from an external combinational instruction
//                memory and drives an external data memory.
//                Supported instructions: add, sub, and, or, slt, addi, lw, sw,
//                beq and j.
//  Ports       : clk        - single clock, all state updates on rising edge
//                reset      - synchronous active-high, clears pc and registers
//                pc         - current instruction byte address
//                instr      - instruction word at pc
//                memWrite   - data-memory write enable (sw only)
//                aluout     - ALU result, also the data-memory address
//                writeData  - rt register value (store data)
//                readData   - data-memory read data (lw)
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        memWrite,
    output logic [31:0] aluout,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    localparam logic [2:0] c_ALU_ADD  = 3'd0;
    localparam logic [2:0] c_ALU_SUB  = 3'd1;
    localparam logic [2:0] c_ALU_AND  = 3'd2;
    localparam logic [2:0] c_ALU_OR   = 3'd3;
    localparam logic [2:0] c_ALU_SLT  = 3'd4;

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_sext;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    logic        w_reg_write;
    logic        w_reg_dst;
    logic        w_alu_src;
    logic        w_mem_to_reg;
    logic        w_mem_write;
    logic        w_branch;
    logic        w_jump;
    logic [2:0]  w_alu_op;

    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_unused_shamt;

    assign w_opcode   = instr[31:26];
    assign w_rs       = instr[25:21];
    assign w_rt       = instr[20:16];
    assign w_rd       = instr[15:11];
    assign w_funct    = instr[5:0];
    assign w_imm_sext = {{16{instr[15]}}, instr[15:0]};

    // Shift amount field has no supported consumer.
    assign w_unused_shamt = ^instr[10:6];

    // $0 is forced to zero on read so it never depends on register contents.
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

    // Main decoder: unknown opcodes/functs leave every control inactive,
    // which yields no register write, no store and a plain pc + 4.
    always_comb begin
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_alu_op     = c_ALU_ADD;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_reg_dst = 1'b1;
                case (w_funct)
                    c_FN_ADD: begin w_reg_write = 1'b1; w_alu_op = c_ALU_ADD; end
                    c_FN_SUB: begin w_reg_write = 1'b1; w_alu_op = c_ALU_SUB; end
                    c_FN_AND: begin w_reg_write = 1'b1; w_alu_op = c_ALU_AND; end
                    c_FN_OR:  begin w_reg_write = 1'b1; w_alu_op = c_ALU_OR;  end
                    c_FN_SLT: begin w_reg_write = 1'b1; w_alu_op = c_ALU_SLT; end
                    default:  w_reg_write = 1'b0;
                endcase
            end
            c_OP_ADDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            c_OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            c_OP_SW: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_OP_BEQ: begin
                w_branch = 1'b1;
                w_alu_op = c_ALU_SUB;
            end
            c_OP_J: begin
                w_jump = 1'b1;
            end
            default: w_reg_write = 1'b0;
        endcase
    end

    assign w_alu_b = w_alu_src ? w_imm_sext : w_rt_val;

    always_comb begin
        w_alu_res = 32'd0;
        case (w_alu_op)
            c_ALU_ADD: w_alu_res = w_rs_val + w_alu_b;
            c_ALU_SUB: w_alu_res = w_rs_val - w_alu_b;
            c_ALU_AND: w_alu_res = w_rs_val & w_alu_b;
            c_ALU_OR:  w_alu_res = w_rs_val | w_alu_b;
            c_ALU_SLT: w_alu_res = {31'd0, ($signed(w_rs_val) < $signed(w_alu_b))};
            default:   w_alu_res = 32'd0;
        endcase
    end

    assign w_wr_addr  = w_reg_dst ? w_rd : w_rt;
    assign w_wr_data  = w_mem_to_reg ? readData : w_alu_res;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_jump) begin
            w_pc_next = {w_pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (w_branch && (w_alu_res == 32'd0)) begin
            w_pc_next = w_pc_plus4 + (w_imm_sext << 2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            r_pc <= w_pc_next;
            if (w_reg_write && (w_wr_addr != 5'd0)) begin
                r_regs[w_wr_addr] <= w_wr_data;
            end
        end
    end

    assign pc        = r_pc;
    assign aluout    = w_alu_res;
    assign writeData = w_rt_val;
    // The store strobe is suppressed while reset is held.
    assign memWrite  = w_mem_write & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_mips_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_core
//  Description : Directed self-checking bench for mips_core. Instructions are
//                driven straight onto instr; register contents are observed
//                combinationally through writeData by presenting an R-type
//                word whose rt field names the register of interest.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_core;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mem_write;
    logic [31:0] aluout;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int checks   = 0;
    int failures = 0;

    mips_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (rst),
        .pc        (pc),
        .instr     (instr),
        .memWrite  (mem_write),
        .aluout    (aluout),
        .writeData (write_data),
        .readData  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Present an instruction and let the combinational path settle.
    task automatic issue(input logic [31:0] ins);
        instr = ins;
        #1;
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read a register through writeData with a harmless add $0,$0,$r.
    task automatic peek(input string tag, input logic [4:0] r, input logic [31:0] exp);
        issue(r_ins(5'd0, r, 5'd0, 6'b100000));
        chk(tag, write_data, exp);
    endtask

    initial begin
        rst       = 1'b1;
        instr     = 32'd0;
        read_data = 32'd0;
        #1;
        // Store presented during reset must not strobe memWrite.
        issue(i_ins(6'b101011, 5'd0, 5'd7, 16'd6));
        chk("memwrite_in_reset", {31'd0, mem_write}, 32'd0);
        tick();
        chk("pc_after_reset", pc, 32'h0);
        rst = 1'b0;

        // addi sequence
        issue(i_ins(6'b001000, 5'd1, 5'd2, 16'd8));
        chk("addi2_alu", aluout, 32'd8);
        tick(); chk("pc_4", pc, 32'd4);
        issue(i_ins(6'b001000, 5'd1, 5'd3, 16'd16));
        chk("addi3_alu", aluout, 32'd16);
        tick(); chk("pc_8", pc, 32'd8);
        issue(i_ins(6'b001000, 5'd1, 5'd6, 16'd5));
        chk("addi6_alu", aluout, 32'd5);
        tick(); chk("pc_12", pc, 32'd12);

        // R-type
        issue(r_ins(5'd3, 5'd6, 5'd4, 6'b100010));
        chk("sub_alu", aluout, 32'd11);
        tick();
        issue(r_ins(5'd2, 5'd3, 5'd5, 6'b100101));
        chk("or_alu", aluout, 32'd24);
        tick();
        issue(r_ins(5'd4, 5'd2, 5'd1, 6'b101010));
        chk("slt_false_alu", aluout, 32'd0);
        tick();
        issue(r_ins(5'd4, 5'd5, 5'd8, 6'b100000));
        chk("add_alu", aluout, 32'd35);
        tick();
        chk("pc_28", pc, 32'd28);
        peek("reg8", 5'd8, 32'd35);
        issue(r_ins(5'd4, 5'd5, 5'd9, 6'b100100));
        chk("and_alu", aluout, 32'd8);

        // Signed compare: -1 < 8
        issue(i_ins(6'b001000, 5'd0, 5'd9, 16'hFFFF));
        chk("addi_neg_alu", aluout, 32'hFFFF_FFFF);
        tick();
        issue(r_ins(5'd9, 5'd2, 5'd10, 6'b101010));
        chk("slt_signed_alu", aluout, 32'd1);
        tick();
        peek("reg10", 5'd10, 32'd1);

        // lw / sw
        read_data = 32'd35;
        issue(i_ins(6'b100011, 5'd1, 5'd7, 16'd6));
        chk("lw_addr", aluout, 32'd6);
        chk("lw_memwrite", {31'd0, mem_write}, 32'd0);
        tick();
        read_data = 32'd0;
        peek("reg7_loaded", 5'd7, 32'd35);
        issue(i_ins(6'b101011, 5'd1, 5'd7, 16'd6));
        chk("sw_memwrite", {31'd0, mem_write}, 32'd1);
        chk("sw_addr", aluout, 32'd6);
        chk("sw_data", write_data, 32'd35);
        tick();
        chk("pc_44", pc, 32'd44);

        // beq taken: 44 + 4 + 8
        issue(i_ins(6'b000100, 5'd8, 5'd7, 16'd2));
        tick();
        chk("beq_taken_pc", pc, 32'd56);
        // beq not taken ($8=35, $2=8)
        issue(i_ins(6'b000100, 5'd8, 5'd2, 16'd2));
        tick();
        chk("beq_not_taken_pc", pc, 32'd60);

        // j 4
        issue({6'b000010, 26'd4});
        chk("j_memwrite", {31'd0, mem_write}, 32'd0);
        tick();
        chk("j_pc", pc, 32'h10);

        // write to $0 ignored
        issue(i_ins(6'b001000, 5'd0, 5'd0, 16'd7));
        chk("addi0_alu", aluout, 32'd7);
        tick();
        peek("reg0_zero", 5'd0, 32'd0);

        // Undefined opcode with rt=$2: no write, no store, pc + 4
        issue(i_ins(6'b111111, 5'd3, 5'd2, 16'd1));
        chk("undef_memwrite", {31'd0, mem_write}, 32'd0);
        tick();
        chk("undef_pc", pc, 32'd24);
        peek("undef_reg2_kept", 5'd2, 32'd8);

        // Mid-program reset
        rst = 1'b1;
        issue(i_ins(6'b101011, 5'd1, 5'd7, 16'd6));
        chk("memwrite_mid_reset", {31'd0, mem_write}, 32'd0);
        tick();
        chk("pc_mid_reset", pc, 32'd0);
        rst = 1'b0;
        peek("reg7_cleared", 5'd7, 32'd0);
        peek("reg8_cleared", 5'd8, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
